// File: rtl/des_sbox_scheduler_pkg.sv
// Shared DES S-layer constants, FSM state encoding, request payload and bit-slice helpers.
package des_sbox_scheduler_pkg;

   localparam int unsigned NUM_SBOX = 8;
   localparam int unsigned CHUNK_W  = 6;
   localparam int unsigned SOUT_W   = 4;
   localparam int unsigned IDX_W    = 3;
   localparam int unsigned DATA_W   = NUM_SBOX * CHUNK_W;
   localparam int unsigned RES_W    = NUM_SBOX * SOUT_W;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      DRAIN,
      RESP
   } state_e;

   typedef struct packed {
      logic              id;
      logic [DATA_W-1:0] data;
   } req_word_t;

   // MSB of the 6-bit input chunk for box k (S1 sits at the top of the word)
   function automatic logic [5:0] chunk_msb(input logic [IDX_W-1:0] k);
      return 6'(DATA_W - 1) - 6'(CHUNK_W) * 6'(k);
   endfunction

   function automatic logic [4:0] res_msb(input logic [IDX_W-1:0] k);
      return 5'(RES_W - 1) - 5'(SOUT_W) * 5'(k);
   endfunction

endpackage

// File: rtl/des_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer remembers who was served last.
module des_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   output logic [1:0] gnt_c_o
);

   logic last_q;
   logic last_d;

   always_comb begin
      gnt_c_o = 2'b00;
      last_d  = last_q;
      if (req_i == 2'b11) begin
         gnt_c_o = last_q ? 2'b01 : 2'b10;
      end else begin
         gnt_c_o = req_i;
      end
      if (upd_i) begin
         last_d = gnt_c_o[1];
      end
   end

   // Reset to "requester 1 served last" so requester 0 wins the first contention
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/des_sbox_scheduler.sv
// Serialises the eight DES S-box lookups of one 48-bit word through a shared external bank.
module des_sbox_scheduler
   import des_sbox_scheduler_pkg::*;
#(
   parameter int unsigned LOOKUP_LAT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              resp_valid,
   output logic [RES_W-1:0]  resp_data,
   output logic              resp_id,
   input  logic              resp_ready,
   output logic [IDX_W-1:0]  sbox_sel,
   output logic [CHUNK_W-1:0] sbox_in,
   input  logic [SOUT_W-1:0] sbox_out,
   output logic              busy
);

   if (LOOKUP_LAT > 1) begin : g_bad_lat
      $error("des_sbox_scheduler: LOOKUP_LAT must be 0 or 1");
   end

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  k_q, k_d;
   req_word_t         word_q, word_d;
   logic [RES_W-1:0]  res_q, res_d;
   logic              live_q;
   logic              cap_en_q, cap_en_d;
   logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;

   logic [1:0]        gnt_c;
   logic              accept_c;
   logic              hs_c;
   logic              issue_c;

   // Requests are only offered in IDLE, and never in or right after reset
   assign accept_c = (state_q == IDLE) & live_q & ~rst;
   assign hs_c     = accept_c & (req0_valid | req1_valid);

   des_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_i   ({req1_valid, req0_valid}),
      .upd_i   (hs_c),
      .gnt_c_o (gnt_c)
   );

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      word_d    = word_q;
      res_d     = res_q;
      cap_en_d  = 1'b0;
      cap_idx_d = cap_idx_q;
      issue_c   = 1'b0;

      // Registered bank: the result of last cycle's issue arrives now
      if (cap_en_q) begin
         res_d[res_msb(cap_idx_q) -: SOUT_W] = sbox_out;
      end

      case (state_q)
         IDLE: begin
            if (hs_c) begin
               word_d.id   = gnt_c[1];
               word_d.data = gnt_c[1] ? req1_data : req0_data;
               res_d       = '0;
               k_d         = '0;
               state_d     = LOOKUP;
            end
         end
         LOOKUP: begin
            issue_c = 1'b1;
            if (LOOKUP_LAT == 0) begin
               res_d[res_msb(k_q) -: SOUT_W] = sbox_out;
            end else begin
               cap_en_d  = 1'b1;
               cap_idx_d = k_q;
            end
            if (k_q == IDX_W'(NUM_SBOX - 1)) begin
               k_d     = '0;
               state_d = (LOOKUP_LAT == 0) ? RESP : DRAIN;
            end else begin
               k_d = k_q + IDX_W'(1);
            end
         end
         DRAIN: begin
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         k_q       <= '0;
         word_q    <= '0;
         res_q     <= '0;
         live_q    <= 1'b0;
         cap_en_q  <= 1'b0;
         cap_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         word_q    <= word_d;
         res_q     <= res_d;
         live_q    <= 1'b1;
         cap_en_q  <= cap_en_d;
         cap_idx_q <= cap_idx_d;
      end
   end

   // Outputs are forced low while reset is asserted
   assign req0_ready = accept_c & gnt_c[0];
   assign req1_ready = accept_c & gnt_c[1];
   assign sbox_sel   = (issue_c & ~rst) ? k_q : '0;
   assign sbox_in    = (issue_c & ~rst) ? word_q.data[chunk_msb(k_q) -: CHUNK_W] : '0;
   assign resp_valid = (state_q == RESP) & ~rst;
   assign resp_data  = resp_valid ? res_q : '0;
   assign resp_id    = resp_valid & word_q.id;
   assign busy       = (state_q != IDLE) & ~rst;

endmodule

// File: doc/des_sbox_scheduler.md
Name: des_sbox_scheduler

Overview:
Sequences the eight DES Feistel S-box substitutions through one shared, externally instantiated S-box lookup bank. It accepts a 48-bit post-expansion/key-XOR word from one of two requesters (encrypt and decrypt round cores) under round-robin arbitration. It then issues eight 6-bit lookups serially and returns the assembled 32-bit S-layer output, tagged with the requester ID, over a valid/ready response handshake.

Parameters:
LOOKUP_LAT, 0, lookup bank latency in cycles. Legal values are 0 (combinational bank) and 1 (registered bank); any other value is a compile-time error.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a word
req0_data  input  48  requester 0 S-layer input; bits [47:42] feed S1, bits [5:0] feed S8
req0_ready  output  1  requester 0 word accepted this cycle when valid and ready are both high
req1_valid  input  1  requester 1 has a word
req1_data  input  48  requester 1 S-layer input, same bit layout as req0_data
req1_ready  output  1  requester 1 accept strobe
resp_valid  output  1  result available
resp_data  output  32  S1 output in [31:28] down to S8 output in [3:0]
resp_id  output  1  requester that owns resp_data
resp_ready  input  1  consumer accepts the result
sbox_sel  output  3  S-box index to the lookup bank, 0 = S1 through 7 = S8
sbox_in  output  6  6-bit lookup input; bits [5] and [0] select the row, bits [4:1] the column
sbox_out  input  4  lookup result
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- State machine: IDLE -> LOOKUP -> (DRAIN, only when LOOKUP_LAT=1) -> RESP -> IDLE.
- Reset:
  - State goes to IDLE and the internal counter k to 0.
  - The round-robin pointer is set so that req0 wins the first contention.
  - All outputs are 0 during reset and on the first cycle after it.
  - Reset mid-operation abandons the word in flight; no response is ever produced for it.
- IDLE:
  - Arbitration is combinational. If exactly one requester is valid, that requester is granted. If both are valid, the requester not served last is granted.
  - Only the granted requester sees ready=1; ready is never high outside IDLE.
  - On handshake: latch data[47:0] and the ID, clear the result register, set k=0, go to LOOKUP, update the pointer.
- LOOKUP, cycle k (k = 0..7):
  - sbox_sel=k, sbox_in=data[47-6k -: 6].
  - LOOKUP_LAT=0: capture sbox_out into result[31-4k -: 4] in the same cycle. After k=7, go to RESP. Eight LOOKUP cycles total.
  - LOOKUP_LAT=1: issues are pipelined; the result for index k is captured in the cycle after it is issued (one delayed index register). After issuing k=7, go to DRAIN. DRAIN captures index 7 and then goes to RESP.
- sbox_sel and sbox_in are 0 whenever no lookup is being issued.
- RESP:
  - resp_valid=1. resp_data and resp_id are held stable until resp_ready=1.
  - On handshake, go to IDLE. resp_valid drops in the next cycle.
  - There is no bypass: the next request handshake occurs at the earliest in the cycle after the response handshake.
- Latency, counting the request-handshake cycle as 0:
  - resp_valid first asserts at cycle 9 for LOOKUP_LAT=0 and at cycle 10 for LOOKUP_LAT=1.
  - Best-case throughput is one word per 10 cycles (LOOKUP_LAT=0) or 11 cycles (LOOKUP_LAT=1).
- Requester valid changes while the FSM is busy are ignored. Requesters must hold valid and data until ready.
- If resp_ready stays low indefinitely, the block remains in RESP and both ready outputs stay low.

Decomposition:
- Shared DES package holds:
  - S-box count (8), chunk width (6), and S-box output width (4).
  - The state enum {IDLE, LOOKUP, DRAIN, RESP}.
  - A function mapping a box index to its chunk MSB (47-6k).
- One sub-module, des_rr_arb2: a two-requester round-robin arbiter with grant outputs, an update strobe, and the last-served pointer register.
- The lookup bank is outside this block.

Test Plan:
- Single request, req0_data=48'h000000000000, LOOKUP_LAT=0, resp_ready=1 -> resp_data=32'hEFA72C4D, resp_id=0, resp_valid first asserted at cycle 9.
- req1_data=48'hFFFFFFFFFFFF, LOOKUP_LAT=1 -> resp_data=32'hD9CE3DCB, resp_id=1, resp_valid at cycle 10. sbox_sel steps 0..7 on consecutive cycles.
- Both requesters valid continuously with distinct data -> grants alternate 0,1,0,1. The ready outputs are never simultaneously high, and each response carries the correct ID.
- resp_ready held low for 20 cycles -> resp_valid, resp_data and resp_id stay constant. Both ready outputs stay 0. After resp_ready rises, the next accept occurs one cycle after the response handshake.
- rst asserted at LOOKUP k=4 -> next cycle all outputs are 0 and no response appears. The pointer is reset, so req0 wins the next contention.
- Idle cycles with no valid requests -> sbox_sel=0, sbox_in=0, busy=0, resp_valid=0.
